// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its grant picker.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 15;
  localparam int WAIT_W      = 3;
  localparam int STARVE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_DBG  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  // Active-low lane write strobes: only a write drives any lane low.
  function automatic logic [3:0] lane_we_n(input logic we, input logic [3:0] be);
    return we ? ~be : 4'hF;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant decision between core and debug requesters.
module dmem_arb_pick
  import dmem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                en,
  input  logic                core_req,
  input  logic                dbg_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_valid,
  output owner_t              grant_owner
);

  logic starved;

  assign starved = (starve_cnt >= STARVE_W'(STARVE_LIM));

  // Core wins ties until debug has watched STARVE_LIM core grants go by.
  always_comb begin
    grant_valid = en & (core_req | dbg_req);
    grant_owner = OWN_CORE;
    if (dbg_req && (!core_req || starved)) begin
      grant_owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data SRAM bank between the core load/store path and the debug port,
// sequencing each access as a multi-cycle SRAM transaction.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_LIM  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_n,
  input  logic              core_we_n,
  input  logic [3:0]        core_be_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall_n,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic [3:0]        sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [31:0]       sram_din
);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                we_r;
  logic [3:0]          be_r;
  logic                core_done;

  logic                pick_en;
  logic                grant_valid;
  owner_t              grant_owner;

  logic                sel_we;
  logic [3:0]          sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  // No new grant in the cycle a completion is being reported.
  assign pick_en      = (state == ST_IDLE) && !core_done && !dbg_ack;
  assign core_stall_n = core_req_n | core_done;

  dmem_arb_pick #(
    .STARVE_LIM(STARVE_LIM)
  ) u_pick (
    .en         (pick_en),
    .core_req   (~core_req_n),
    .dbg_req    (dbg_req),
    .starve_cnt (starve_cnt),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_comb begin
    sel_we    = ~core_we_n;
    sel_be    = ~core_be_n;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    if (grant_owner == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_be    = dbg_be;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      starve_cnt   <= '0;
      we_r         <= 1'b0;
      be_r         <= '0;
      core_done    <= 1'b0;
      dbg_ack      <= 1'b0;
      core_rdata   <= '0;
      dbg_rdata    <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 4'hF;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
    end else begin
      core_done <= 1'b0;
      dbg_ack   <= 1'b0;
      if (!dbg_req) begin
        starve_cnt <= '0;
      end
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state        <= (grant_owner == OWN_DBG) ? ST_DBG : ST_CORE;
            wait_cnt     <= WAIT_W'(WAIT_CYCLES);
            we_r         <= sel_we;
            be_r         <= sel_be;
            sram_addr    <= sel_addr;
            sram_dout    <= sel_wdata;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= sel_we;
            sram_dout_en <= sel_we;
            // With no wait states the first access cycle is also the last.
            sram_we_n    <= (WAIT_CYCLES == 0) ? lane_we_n(sel_we, sel_be) : 4'hF;
            if (grant_owner == OWN_DBG) begin
              starve_cnt <= '0;
            end else if (dbg_req) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end
        end
        ST_CORE, ST_DBG: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1)) begin
              sram_we_n <= lane_we_n(we_r, be_r);
            end
          end else begin
            state        <= ST_IDLE;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 4'hF;
            sram_dout_en <= 1'b0;
            if (state == ST_CORE) begin
              core_done <= 1'b1;
              if (!we_r) begin
                core_rdata <= sram_din;
              end
            end else begin
              dbg_ack <= 1'b1;
              if (!we_r) begin
                dbg_rdata <= sram_din;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
